// File: rtl/tc_alu_issue_pkg.sv
// Shared types and constants for the TC ALU issue/retire sequencer.
package tc_alu_pkg;

  localparam int   TC_OP_W    = 8;
  localparam int   TC_RES_W   = 16;
  localparam logic TC_SEL_ADD = 1'b0;
  localparam logic TC_SEL_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    HOLD
  } tc_alu_state_t;

  typedef struct packed {
    logic [TC_OP_W-1:0] a;
    logic [TC_OP_W-1:0] b;
    logic               sel;
  } tc_alu_cmd_t;

endpackage

// File: rtl/tc_alu_issue_if.sv
// Command-in / result-out stream bundle of the TC ALU issue stage.
interface tc_alu_issue_if;
  import tc_alu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [TC_OP_W-1:0]  in_a;
  logic [TC_OP_W-1:0]  in_b;
  logic                in_sel;
  logic                out_valid;
  logic                out_ready;
  logic [TC_RES_W-1:0] out_y;
  logic                out_sel;

  // master is the environment (command producer and result consumer).
  modport master (
    output in_valid, in_a, in_b, in_sel, out_ready,
    input  in_ready, out_valid, out_y, out_sel
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, out_ready,
    output in_ready, out_valid, out_y, out_sel
  );

endinterface

// File: rtl/tc_alu_issue_cmd_fifo.sv
// Synchronous command FIFO; the head entry is visible on pop_data without a read latency.
module tc_alu_cmd_fifo
  import tc_alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  tc_alu_cmd_t                  push_data,
  input  logic                         pop,
  output tc_alu_cmd_t                  pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  tc_alu_cmd_t       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) wide so they wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tc_alu_issue.sv
// Issue/retire sequencer wrapping the combinational TC ALU as a flow-controlled stage:
// buffers commands, drives operands for SETTLE cycles, then holds the captured result.
module tc_alu_issue
  import tc_alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  tc_alu_issue_if.slave               bus,
  output logic [TC_OP_W-1:0]          alu_a,
  output logic [TC_OP_W-1:0]          alu_b,
  output logic                        alu_sel,
  input  logic [TC_RES_W-1:0]         alu_y,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

  if (SETTLE < 1) begin : g_settle_check
    $error("tc_alu_issue: SETTLE must be at least 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("tc_alu_issue: DEPTH must be a power of two, at least 2");
  end

  localparam int                CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);

  tc_alu_state_t     state;
  logic [CNT_W-1:0]  cnt;
  tc_alu_cmd_t       cmd_in;
  tc_alu_cmd_t       head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_req;
  logic              pop_req;
  logic              handshake;

  assign cmd_in.a     = bus.in_a;
  assign cmd_in.b     = bus.in_b;
  assign cmd_in.sel   = bus.in_sel;
  assign bus.in_ready = !fifo_full;
  assign push_req     = bus.in_valid && !fifo_full;
  assign handshake    = bus.out_valid && bus.out_ready;
  assign pop_req      = !fifo_empty && ((state == IDLE) || ((state == HOLD) && handshake));

  tc_alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (cmd_in),
    .pop       (pop_req),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Operands only move on a pop, so the ALU sees them stable for the whole settle window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_sel       <= TC_SEL_ADD;
      bus.out_valid <= 1'b0;
      bus.out_y     <= '0;
      bus.out_sel   <= TC_SEL_ADD;
    end else begin
      case (state)
        IDLE: begin
          if (pop_req) begin
            alu_a   <= head.a;
            alu_b   <= head.b;
            alu_sel <= head.sel;
            cnt     <= SETTLE_LAST;
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            bus.out_y     <= alu_y;
            bus.out_sel   <= alu_sel;
            bus.out_valid <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (handshake) begin
            bus.out_valid <= 1'b0;
            if (pop_req) begin
              alu_a   <= head.a;
              alu_b   <= head.b;
              alu_sel <= head.sel;
              cnt     <= SETTLE_LAST;
              state   <= DRIVE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_alu_issue.sv
// Self-checking bench for tc_alu_issue: one instance with SETTLE=1, one with SETTLE=3,
// each wrapped around a behavioural TC ALU, checked against a result scoreboard.
module tb_tc_alu_issue;
  import tc_alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        use3;
  logic        tb_in_valid;
  logic [7:0]  tb_in_a;
  logic [7:0]  tb_in_b;
  logic        tb_in_sel;
  logic        tb_out_ready;

  int vectors     = 0;
  int miscompares = 0;

  tc_alu_issue_if bus1 ();
  tc_alu_issue_if bus3 ();

  logic [7:0]  alu_a1, alu_b1, alu_a3, alu_b3;
  logic        alu_sel1, alu_sel3;
  logic [15:0] alu_y1, alu_y3;
  logic [2:0]  cnt1, cnt3;

  assign bus1.in_valid  = use3 ? 1'b0 : tb_in_valid;
  assign bus1.in_a      = tb_in_a;
  assign bus1.in_b      = tb_in_b;
  assign bus1.in_sel    = tb_in_sel;
  assign bus1.out_ready = use3 ? 1'b0 : tb_out_ready;
  assign bus3.in_valid  = use3 ? tb_in_valid : 1'b0;
  assign bus3.in_a      = tb_in_a;
  assign bus3.in_b      = tb_in_b;
  assign bus3.in_sel    = tb_in_sel;
  assign bus3.out_ready = use3 ? tb_out_ready : 1'b0;

  // Behavioural TC ALU: zero-extended 9-bit sum or full 16-bit product.
  assign alu_y1 = alu_sel1 ? (16'(alu_a1) * 16'(alu_b1)) : (16'(alu_a1) + 16'(alu_b1));
  assign alu_y3 = alu_sel3 ? (16'(alu_a3) * 16'(alu_b3)) : (16'(alu_a3) + 16'(alu_b3));

  tc_alu_issue #(.DEPTH(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1), .alu_y(alu_y1), .fifo_count(cnt1)
  );

  tc_alu_issue #(.DEPTH(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3), .alu_y(alu_y3), .fifo_count(cnt3)
  );

  logic        m_in_ready, m_out_valid, m_out_sel;
  logic [15:0] m_out_y;
  logic [2:0]  m_fifo_count;
  logic [7:0]  m_alu_a;

  assign m_in_ready   = use3 ? bus3.in_ready  : bus1.in_ready;
  assign m_out_valid  = use3 ? bus3.out_valid : bus1.out_valid;
  assign m_out_sel    = use3 ? bus3.out_sel   : bus1.out_sel;
  assign m_out_y      = use3 ? bus3.out_y     : bus1.out_y;
  assign m_fifo_count = use3 ? cnt3           : cnt1;
  assign m_alu_a      = use3 ? alu_a3         : alu_a1;

  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] y;
    if (s == TC_SEL_MUL) y = 16'(a) * 16'(b);
    else                 y = 16'(a) + 16'(b);
    return {s, y};
  endfunction

  // Scoreboard: every accepted command queues its expected {sel, y}.
  logic [16:0] exp_q [$];
  always @(posedge clk) begin
    if (!rst && tb_in_valid && m_in_ready) exp_q.push_back(model(tb_in_a, tb_in_b, tb_in_sel));
  end

  task automatic drive_cmd(input logic [7:0] a, input logic [7:0] b, input logic s);
    tb_in_valid = 1'b1;
    tb_in_a     = a;
    tb_in_b     = b;
    tb_in_sel   = s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (bus1.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %0h want 1", bus1.in_ready); end
    vectors++; if (bus1.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %0h want 0", bus1.out_valid); end
    vectors++; if (bus1.out_y !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_out_y: got %0h want 0", bus1.out_y); end
    vectors++; if (bus1.out_sel !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_sel: got %0h want 0", bus1.out_sel); end
    vectors++; if ({alu_a1, alu_b1, alu_sel1} !== 17'h0) begin miscompares++; $display("[TB] FAIL reset_alu_ops: got %0h want 0", {alu_a1, alu_b1, alu_sel1}); end
    vectors++; if (cnt1 !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_fifo_count: got %0d want 0", cnt1); end
    vectors++; if ({bus3.out_valid, cnt3} !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_dut3: got %0h want 0", {bus3.out_valid, cnt3}); end
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_add();
    logic [16:0] e;
    @(negedge clk);
    tb_out_ready = 1'b1;
    drive_cmd(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    tb_in_valid = 1'b0;
    vectors++; if (m_out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_latency_e1: got %0h want 0", m_out_valid); end
    @(negedge clk);
    vectors++; if (m_out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_latency_e2: got %0h want 0", m_out_valid); end
    @(negedge clk);
    vectors++; if (m_out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL add_latency_e3: got %0h want 1", m_out_valid); end
    vectors++; if ({m_out_sel, m_out_y} !== {1'b0, 16'h0046}) begin miscompares++; $display("[TB] FAIL add_result: got %0h want 0046", {m_out_sel, m_out_y}); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1ffff;
    vectors++; if ({m_out_sel, m_out_y} !== e) begin miscompares++; $display("[TB] FAIL add_scoreboard: got %0h want %0h", {m_out_sel, m_out_y}, e); end
    @(negedge clk);
    vectors++; if (m_out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_valid_drop: got %0h want 0", m_out_valid); end
  endtask

  task automatic test_mul_add();
    logic [15:0] want_y [2];
    logic [16:0] e;
    int got = 0;
    want_y[0] = 16'hFE01;
    want_y[1] = 16'h01FE;
    tb_out_ready = 1'b1;
    @(negedge clk); drive_cmd(8'hFF, 8'hFF, 1'b1);
    @(negedge clk); drive_cmd(8'hFF, 8'hFF, 1'b0);
    @(negedge clk); tb_in_valid = 1'b0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      if (m_out_valid && tb_out_ready) begin
        vectors++; if (m_out_y !== want_y[got]) begin miscompares++; $display("[TB] FAIL mul_add_const[%0d]: got %0h want %0h", got, m_out_y, want_y[got]); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1ffff;
        vectors++; if ({m_out_sel, m_out_y} !== e) begin miscompares++; $display("[TB] FAIL mul_add_sb[%0d]: got %0h want %0h", got, {m_out_sel, m_out_y}, e); end
        got++;
      end
      @(negedge clk);
    end
    vectors++; if (got != 2) begin miscompares++; $display("[TB] FAIL mul_add_timeout: got %0d results want 2", got); end
  endtask

  task automatic test_stall();
    logic [16:0] e;
    logic acc = 1'b0;
    int k = 0;
    int got = 0;
    tb_out_ready = 1'b0;
    drive_cmd(8'h10, 8'h20, 1'b0);
    acc = m_in_ready;
    repeat (12) begin
      @(negedge clk);
      if (acc) k++;
      if (k < 6) drive_cmd(8'h10 + 8'(k), 8'h20 + 8'(k), k[0]);
      else tb_in_valid = 1'b0;
      acc = (k < 6) && m_in_ready;
    end
    vectors++; if (k != 5) begin miscompares++; $display("[TB] FAIL stall_accepted: got %0d want 5", k); end
    vectors++; if (m_in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_in_ready: got %0h want 0", m_in_ready); end
    vectors++; if (m_fifo_count !== 3'd4) begin miscompares++; $display("[TB] FAIL stall_fifo_count: got %0d want 4", m_fifo_count); end
    repeat (10) begin
      vectors++; if ({m_out_valid, m_out_sel, m_out_y} !== {1'b1, 1'b0, 16'h0030}) begin miscompares++; $display("[TB] FAIL stall_hold: got %0h want 10030", {m_out_valid, m_out_sel, m_out_y}); end
      @(negedge clk);
    end
    tb_in_valid  = 1'b0;
    tb_out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (m_out_valid && tb_out_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1ffff;
        vectors++; if ({m_out_sel, m_out_y} !== e) begin miscompares++; $display("[TB] FAIL stall_drain[%0d]: got %0h want %0h", got, {m_out_sel, m_out_y}, e); end
        got++;
      end
      @(negedge clk);
    end
    vectors++; if (got != 5) begin miscompares++; $display("[TB] FAIL stall_drain_timeout: got %0d results want 5", got); end
  endtask

  task automatic test_simul_push_pop();
    logic [16:0] e;
    int got = 0;
    tb_out_ready = 1'b0;
    drive_cmd(8'h01, 8'h02, 1'b0);
    @(negedge clk); drive_cmd(8'h03, 8'h04, 1'b1);
    @(negedge clk); drive_cmd(8'h05, 8'h06, 1'b0);
    @(negedge clk); tb_in_valid = 1'b0;
    vectors++; if ({m_out_valid, m_fifo_count} !== {1'b1, 3'd2}) begin miscompares++; $display("[TB] FAIL simul_setup: got %0h want a", {m_out_valid, m_fifo_count}); end
    vectors++; if (m_out_y !== 16'h0003) begin miscompares++; $display("[TB] FAIL simul_first: got %0h want 0003", m_out_y); end
    if (exp_q.size() != 0) e = exp_q.pop_front();
    tb_out_ready = 1'b1;
    drive_cmd(8'h07, 8'h08, 1'b1);
    vectors++; if (m_in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL simul_in_ready: got %0h want 1", m_in_ready); end
    @(negedge clk);
    tb_in_valid = 1'b0;
    vectors++; if ({m_out_valid, m_fifo_count} !== {1'b0, 3'd2}) begin miscompares++; $display("[TB] FAIL simul_count: got %0h want 2", {m_out_valid, m_fifo_count}); end
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (m_out_valid && tb_out_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1ffff;
        vectors++; if ({m_out_sel, m_out_y} !== e) begin miscompares++; $display("[TB] FAIL simul_order[%0d]: got %0h want %0h", got, {m_out_sel, m_out_y}, e); end
        got++;
      end
      @(negedge clk);
    end
    vectors++; if (got != 3) begin miscompares++; $display("[TB] FAIL simul_timeout: got %0d results want 3", got); end
  endtask

  task automatic test_throughput(input logic s3);
    logic [7:0]  ca [8];
    logic [7:0]  cb [8];
    logic        cs [8];
    logic [16:0] e;
    logic acc = 1'b0;
    int k = 0, got = 0, cyc = 0, last = 0;
    int gap_want = s3 ? 4 : 2;
    for (int i = 0; i < 8; i++) begin
      ca[i] = 8'($urandom_range(255));
      cb[i] = 8'($urandom_range(255));
      cs[i] = 1'($urandom_range(1));
    end
    use3 = s3;
    tb_out_ready = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 100 && got < 8; c++) begin
      if (m_out_valid && tb_out_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1ffff;
        vectors++; if ({m_out_sel, m_out_y} !== e) begin miscompares++; $display("[TB] FAIL thru%0d_result[%0d]: got %0h want %0h", gap_want, got, {m_out_sel, m_out_y}, e); end
        if (got > 0) begin
          vectors++; if (cyc - last != gap_want) begin miscompares++; $display("[TB] FAIL thru%0d_gap[%0d]: got %0d want %0d", gap_want, got, cyc - last, gap_want); end
        end
        last = cyc;
        got++;
      end
      if (acc) k++;
      if (k < 8) drive_cmd(ca[k], cb[k], cs[k]);
      else tb_in_valid = 1'b0;
      acc = (k < 8) && m_in_ready;
      @(negedge clk);
      cyc++;
    end
    tb_in_valid = 1'b0;
    vectors++; if (got != 8) begin miscompares++; $display("[TB] FAIL thru%0d_timeout: got %0d results want 8", gap_want, got); end
  endtask

  task automatic test_reset_mid();
    use3 = 1'b1;
    tb_out_ready = 1'b0;
    drive_cmd(8'h55, 8'h11, 1'b0);
    @(negedge clk); drive_cmd(8'h66, 8'h22, 1'b1);
    @(negedge clk); drive_cmd(8'h77, 8'h33, 1'b0);
    @(negedge clk); tb_in_valid = 1'b0;
    vectors++; if ({m_out_valid, m_fifo_count} !== {1'b0, 3'd2}) begin miscompares++; $display("[TB] FAIL rstmid_setup: got %0h want 2", {m_out_valid, m_fifo_count}); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if ({m_out_valid, m_fifo_count, m_alu_a, m_in_ready} !== {1'b0, 3'd0, 8'h00, 1'b1}) begin miscompares++; $display("[TB] FAIL rstmid_state: got %0h want 1", {m_out_valid, m_fifo_count, m_alu_a, m_in_ready}); end
    rst = 1'b0;
    exp_q.delete();
    tb_out_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      vectors++; if (m_out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_no_result: got %0h want 0", m_out_valid); end
    end
  endtask

  initial begin
    rst          = 1'b1;
    use3         = 1'b0;
    tb_in_valid  = 1'b0;
    tb_in_a      = '0;
    tb_in_b      = '0;
    tb_in_sel    = 1'b0;
    tb_out_ready = 1'b0;
    test_reset();
    test_add();
    test_mul_add();
    test_stall();
    test_simul_push_pop();
    test_throughput(1'b0);
    test_throughput(1'b1);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
